pmp_checker: RTL and testbench
==============================

# pmp_checker

Sequential PMP permission checker that sits directly downstream of the `napot` address matcher. It accepts one access request at a time and scans the PMP entries in priority order, one entry per cycle. For each entry it decodes the address-matching mode, using an internal `napot` instance for NAPOT entries. It stops at the first matching entry and returns a fault/allow verdict through a valid/ready response handshake.

## Interface
Parameters:
- `NUM_ENTRIES`, default 16: number of PMP entries scanned; legal range 1–16.

Ports:
- `clk`  in  1  clock. One clock only; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_addr`  in  32  access base address (unsigned).
- `req_size`  in  2  access size: 00 byte, 01 half-word, 10 word, 11 illegal.
- `req_type`  in  2  access type: 00 read, 01 write, 10 execute, 11 illegal.
- `req_priv_m`  in  1  1 = machine mode.
- `pmpcfg_i`  in  8*NUM_ENTRIES  config byte per entry. Byte i holds entry i. Bit layout: [0] R, [1] W, [2] X, [4:3] A (00 OFF, 01 TOR, 10 NA4, 11 NAPOT), [7] L.
- `pmpaddr_i`  in  32*NUM_ENTRIES  address word per entry. Word i holds entry i, in the same units as `req_addr`.
- `resp_valid`  out  1  verdict available.
- `resp_ready`  in  1  consumer accepts the verdict.
- `resp_fault`  out  1  access denied.
- `resp_hit`  out  1  some entry matched.
- `resp_entry`  out  4  index of the matching entry; 0 when there is no hit.

## Operation
- FSM states: IDLE, SCAN, RESP.
- `req_ready` = (state == IDLE), driven combinationally.
- IDLE:
  - On `req_valid && req_ready`, latch addr, size, type and priv.
  - Clear `idx` to 0 and go to SCAN.
- SCAN evaluates entry `idx` combinationally each cycle:
  - `end_addr` = {1'b0, addr} + size, 33 bits wide. A carry out (bit 32 set) forces no-match in every mode.
  - OFF: never matches.
  - TOR: matches if `lo <= addr` and `end_addr < pmpaddr[idx]`.
    - `lo` = `pmpaddr[idx-1]`, or 0 when `idx` = 0.
    - `lo` is used even when entry `idx-1` is OFF.
  - NA4: matches if `pmpaddr[idx] <= addr` and `end_addr <= pmpaddr[idx] + 3`.
  - NAPOT: matches when the `napot` instance output is 1, with that instance driven by addr = latched addr, addr_n = `pmpaddr[idx]`, size = latched size.
  - On a match: latch `hit`=1, `entry`=`idx` and the permission bits, then go to RESP.
  - No match and `idx == NUM_ENTRIES-1`: latch `hit`=0, then go to RESP.
  - Otherwise increment `idx`.
- Fault rules, evaluated at the move into RESP; the first rule that applies wins:
  - type 11 or size 11: fault = 1.
  - Miss: fault = !priv_m.
  - Hit, priv_m = 1, L = 0: fault = 0.
  - Otherwise fault = !(required bit), where the required bit is R for read, W for write, X for execute.
- RESP:
  - Hold `resp_*` stable while `resp_valid` = 1.
  - On `resp_ready`, return to IDLE.
- `pmpcfg_i` and `pmpaddr_i` are sampled live during SCAN. They must stay stable from request acceptance until the response handshake; the CSR write path stalls to guarantee this.

## Timing
- Reset values: state IDLE, `req_ready` = 1, `resp_valid` = 0, `resp_fault` = 0, `resp_hit` = 0, `resp_entry` = 0, `idx` = 0.
- Latency:
  - A request accepted at edge 0 evaluates entry k in cycle k+1.
  - A hit on entry k raises `resp_valid` after edge k+2.
  - A miss raises `resp_valid` after edge NUM_ENTRIES+1.
- Throughput: one request per transaction. `req_ready` falls the cycle after acceptance and rises the cycle after the response handshake. A new request is never accepted in the same cycle as the response handshake.
- `req_valid` while busy is ignored; no queuing.
- `rst` mid-transaction aborts the scan immediately. No response is produced for the aborted request.

## Test plan
- NAPOT hit: cfg[0]=0x19 (NAPOT, R), pmpaddr[0]=0x0000_1003 (region 0x1000–0x101F), all other entries OFF; user read of 0x1010, size 10 -> `resp_hit`=1, `resp_entry`=0, `resp_fault`=0, valid 2 cycles after accept. The same access as a write -> `resp_fault`=1.
- Boundary straddle: same setup; user read at 0x101E, size 10 (end 0x1020) -> `resp_hit`=0, `resp_fault`=1, valid after NUM_ENTRIES+1 cycles. The same access in machine mode -> `resp_fault`=0.
- Priority plus TOR:
  - Setup: entry 1 OFF with pmpaddr=0x2000; entry 2 TOR, X only, pmpaddr=0x3000; entry 5 NAPOT, RWX, covering 0x2000–0x3FFF.
  - Stimulus: user execute at 0x2800 -> `resp_entry`=2, fault 0, latency 4.
  - Stimulus: user write at 0x2800 -> entry 2, fault 1.
- Lock: cfg[0]=0x99 (L, NAPOT, R only); machine write into the region -> fault 1. Clear L -> fault 0.
- Backpressure/illegal: hold `resp_ready`=0 for 5 cycles -> `resp_*` stable, `req_ready`=0, and a pulsed `req_valid` is not accepted. A request with type 11 -> fault 1.
- Reset mid-scan: assert `rst` during SCAN at idx=3 -> next cycle `resp_valid`=0, `req_ready`=1, and all outputs at their reset values.

Source files
------------

// File: rtl/pmp_checker.sv
// pmp_checker -- sequential PMP permission checker.
//
// Accepts one access request at a time. It scans the PMP entries in priority
// order, one entry per cycle, and stops at the first entry that matches. It
// then holds a fault/allow verdict on a valid/ready response port until the
// consumer takes it.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (ready only while idle)
//   req_addr  [31:0]    access base address
//   req_size  [1:0]     00 byte, 01 half, 10 word, 11 illegal
//   req_type  [1:0]     00 read, 01 write, 10 execute, 11 illegal
//   req_priv_m          1 = machine mode
//   pmpcfg_i            8 bits per entry: [0]R [1]W [2]X [4:3]A [7]L
//   pmpaddr_i           32 bits per entry, same units as req_addr
//   resp_valid/ready    response handshake
//   resp_fault          access denied
//   resp_hit            some entry matched
//   resp_entry [3:0]    matching entry index, 0 on a miss
//
// The napot helper is defined in this file. It matches an access against a
// naturally aligned power-of-two region.

// napot -- combinational NAPOT region match.
//   addr   [31:0] access base address
//   addr_n [31:0] encoded region: trailing ones t give a region of 2^(t+3)
//                 bytes, based at addr_n with those low t+3 bits cleared
//   size   [1:0]  added to addr to form the access end address
//   match         both ends of the access lie inside the region
module napot (
  input  logic [31:0] addr,
  input  logic [31:0] addr_n,
  input  logic [1:0]  size,
  output logic        match
);
  logic [31:0] ones;
  logic [31:0] mask;
  logic [32:0] end_addr;

  // x ^ (x+1) yields the trailing ones plus the first zero above them, which
  // is t+1 ones. Shifting left by two and filling the bottom gives t+3 ones.
  // An all-ones addr_n wraps to an all-ones mask and covers the whole space.
  assign ones     = addr_n ^ (addr_n + 32'd1);
  assign mask     = (ones << 2) | 32'd3;
  assign end_addr = {1'b0, addr} + {31'd0, size};
  assign match    = !end_addr[32]
                    && ((addr & ~mask) == (addr_n & ~mask))
                    && ((end_addr[31:0] & ~mask) == (addr_n & ~mask));
endmodule

module pmp_checker #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [1:0]               req_type,
  input  logic                     req_priv_m,
  input  logic [8*NUM_ENTRIES-1:0] pmpcfg_i,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr_i,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_fault,
  output logic                     resp_hit,
  output logic [3:0]               resp_entry
);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);
  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q, type_q;
  logic        priv_q;
  logic        hit_q, hit_d;
  logic        fault_q, fault_d;
  logic [3:0]  entry_q, entry_d;
  logic        capture;

  // Unpack the flat CSR buses into a fixed 16-slot table, so a 4-bit index
  // always selects in range. Slots beyond NUM_ENTRIES read as OFF at address 0.
  logic [7:0]  cfg_arr  [16];
  logic [31:0] addr_arr [16];

  for (genvar i = 0; i < 16; i++) begin : g_unpack
    if (i < NUM_ENTRIES) begin : g_live
      assign cfg_arr[i]  = pmpcfg_i[8*i +: 8];
      assign addr_arr[i] = pmpaddr_i[32*i +: 32];
    end else begin : g_pad
      assign cfg_arr[i]  = 8'd0;
      assign addr_arr[i] = 32'd0;
    end
  end

  // Evaluation of the current entry.
  logic [7:0]  cur_cfg;
  logic [31:0] cur_addr;
  logic [31:0] lo;
  logic [32:0] end_addr;
  logic        tor_match, na4_match, napot_match, match;
  logic        illegal, req_bit, fault_hit, fault_miss;

  assign cur_cfg  = cfg_arr[idx_q];
  assign cur_addr = addr_arr[idx_q];
  // The TOR lower bound comes from the previous entry's address, whatever
  // that entry's own mode is.
  assign lo       = (idx_q == 4'd0) ? 32'd0 : addr_arr[idx_q - 4'd1];
  assign end_addr = {1'b0, addr_q} + {31'd0, size_q};

  assign tor_match = (lo <= addr_q) && (end_addr < {1'b0, cur_addr});
  assign na4_match = (cur_addr <= addr_q)
                     && (end_addr <= ({1'b0, cur_addr} + 33'd3));

  napot u_napot (
    .addr   (addr_q),
    .addr_n (cur_addr),
    .size   (size_q),
    .match  (napot_match)
  );

  always_comb begin
    match = 1'b0;
    unique case (cur_cfg[4:3])
      A_OFF:   match = 1'b0;
      A_TOR:   match = tor_match;
      A_NA4:   match = na4_match;
      A_NAPOT: match = napot_match;
    endcase
    // An access whose end wraps past 2^32 never matches any entry.
    if (end_addr[32]) match = 1'b0;
  end

  assign illegal = (type_q == 2'b11) || (size_q == 2'b11);

  always_comb begin
    req_bit = 1'b0;
    unique case (type_q)
      2'b00:   req_bit = cur_cfg[0];
      2'b01:   req_bit = cur_cfg[1];
      2'b10:   req_bit = cur_cfg[2];
      default: req_bit = 1'b0;
    endcase
  end

  // Machine mode bypasses unlocked entries. Locked entries and user mode
  // both enforce the permission bit.
  assign fault_hit  = illegal ? 1'b1 : ((priv_q && !cur_cfg[7]) ? 1'b0 : !req_bit);
  assign fault_miss = illegal ? 1'b1 : !priv_q;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    entry_d = entry_q;
    fault_d = fault_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          entry_d = idx_q;
          fault_d = fault_hit;
          state_d = RESP;
        end else if (idx_q == LAST_IDX) begin
          hit_d   = 1'b0;
          entry_d = 4'd0;
          fault_d = fault_miss;
          state_d = RESP;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      hit_q   <= 1'b0;
      entry_q <= 4'd0;
      fault_q <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      type_q  <= 2'd0;
      priv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      entry_q <= entry_d;
      fault_q <= fault_d;
      if (capture) begin
        addr_q <= req_addr;
        size_q <= req_size;
        type_q <= req_type;
        priv_q <= req_priv_m;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_fault = fault_q;
  assign resp_hit   = hit_q;
  assign resp_entry = entry_q;
endmodule

// File: tb/tb_pmp_checker.sv
// tb_pmp_checker -- directed self-checking bench for pmp_checker.
// Each vector carries hand-computed expected verdicts and latencies. The
// latency counts rising edges from the accepting edge (edge 1) through the
// edge after which resp_valid is first seen high. A hit on entry k gives k+2;
// a miss gives NUM_ENTRIES+1.
module tb_pmp_checker;
  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [31:0]     req_addr = '0;
  logic [1:0]      req_size = '0;
  logic [1:0]      req_type = '0;
  logic            req_priv_m = 1'b0;
  logic [8*N-1:0]  pmpcfg_i;
  logic [32*N-1:0] pmpaddr_i;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic            resp_fault;
  logic            resp_hit;
  logic [3:0]      resp_entry;

  logic [7:0]  cfg  [N];
  logic [31:0] addr [N];

  always_comb begin
    pmpcfg_i  = '0;
    pmpaddr_i = '0;
    for (int i = 0; i < N; i++) begin
      pmpcfg_i[8*i +: 8]   = cfg[i];
      pmpaddr_i[32*i +: 32] = addr[i];
    end
  end

  pmp_checker #(.NUM_ENTRIES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_type   (req_type),
    .req_priv_m (req_priv_m),
    .pmpcfg_i   (pmpcfg_i),
    .pmpaddr_i  (pmpaddr_i),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_fault (resp_fault),
    .resp_hit   (resp_hit),
    .resp_entry (resp_entry)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < N; i++) begin
      cfg[i]  = 8'h00;
      addr[i] = 32'h0;
    end
  endtask

  // Issue one request and wait for resp_valid. The response is left pending.
  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [1:0] t,
                       input logic p, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = s;
    req_type   = t;
    req_priv_m = p;
    @(posedge clk);
    lat = 1;
    #1;
    req_valid = 1'b0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
  endtask

  task automatic complete();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  // Issue a request, check its verdict and latency, then complete it.
  task automatic txn(input string tag, input logic [31:0] a, input logic [1:0] s,
                     input logic [1:0] t, input logic p, input logic exp_hit,
                     input logic [3:0] exp_entry, input logic exp_fault, input int exp_lat);
    int lat;
    issue(a, s, t, p, lat);
    check({tag, ".hit"},   32'(resp_hit),   32'(exp_hit));
    check({tag, ".entry"}, 32'(resp_entry), 32'(exp_entry));
    check({tag, ".fault"}, 32'(resp_fault), 32'(exp_fault));
    if (exp_lat > 0) check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    complete();
  endtask

  initial begin
    logic       f0, h0;
    logic [3:0] e0;
    int         lat;

    clear_tables();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready",  32'(req_ready),  32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.fault",      32'(resp_fault), 32'd0);
    check("rst.hit",        32'(resp_hit),   32'd0);
    check("rst.entry",      32'(resp_entry), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // NAPOT region 0x1000-0x101F, read only.
    cfg[0]  = 8'h19;
    addr[0] = 32'h0000_1003;
    txn("napot_rd",   32'h1010, 2'b10, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 2);
    txn("napot_wr",   32'h1010, 2'b10, 2'b01, 1'b0, 1'b1, 4'd0, 1'b1, 2);
    // End address 0x1020 leaves the region, so the scan misses every entry.
    txn("straddle_u", 32'h101E, 2'b10, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1, N + 1);
    txn("straddle_m", 32'h101E, 2'b10, 2'b00, 1'b1, 1'b0, 4'd0, 1'b0, N + 1);

    // Priority and TOR: entry 2 covers [0x2000, 0x3000) X only; entry 5 is
    // NAPOT 0x2000-0x3FFF RWX.
    clear_tables();
    addr[1] = 32'h2000;
    cfg[2]  = 8'h0C;
    addr[2] = 32'h3000;
    cfg[5]  = 8'h1F;
    addr[5] = 32'h0000_23FF;
    txn("tor_x",   32'h2800, 2'b10, 2'b10, 1'b0, 1'b1, 4'd2, 1'b0, 4);
    txn("tor_w",   32'h2800, 2'b10, 2'b01, 1'b0, 1'b1, 4'd2, 1'b1, 4);
    // End 0x3000 is not below the TOR top, so the scan falls through to entry 5.
    txn("tor_top", 32'h2FFE, 2'b10, 2'b10, 1'b0, 1'b1, 4'd5, 1'b0, 7);
    txn("tor_lo",  32'h1FFF, 2'b00, 2'b10, 1'b0, 1'b0, 4'd0, 1'b1, N + 1);

    // Locked entry binds machine mode too.
    clear_tables();
    cfg[0]  = 8'h99;
    addr[0] = 32'h0000_1003;
    txn("lock_mw",   32'h1010, 2'b10, 2'b01, 1'b1, 1'b1, 4'd0, 1'b1, 2);
    cfg[0] = 8'h19;
    txn("unlock_mw", 32'h1010, 2'b10, 2'b01, 1'b1, 1'b1, 4'd0, 1'b0, 2);

    // Backpressure: hold the response 5 cycles, pulse a stray request.
    issue(32'h1010, 2'b10, 2'b00, 1'b0, lat);
    f0 = resp_fault;
    h0 = resp_hit;
    e0 = resp_entry;
    check("bp.hit",   32'(h0), 32'd1);
    check("bp.fault", 32'(f0), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = (c == 2);
      req_addr  = 32'h2222;
      req_type  = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("bp.valid", 32'(resp_valid), 32'd1);
      check("bp.ready", 32'(req_ready),  32'd0);
      check("bp.fault_hold", 32'(resp_fault), 32'(f0));
      check("bp.hit_hold",   32'(resp_hit),   32'(h0));
      check("bp.entry_hold", 32'(resp_entry), 32'(e0));
    end
    complete();
    check("bp.after_valid", 32'(resp_valid), 32'd0);
    check("bp.after_ready", 32'(req_ready),  32'd1);
    repeat (N + 4) @(posedge clk);
    #1;
    check("bp.no_stray", 32'(resp_valid), 32'd0);

    // Illegal encodings fault even where the region grants access.
    txn("illegal_type", 32'h1010, 2'b10, 2'b11, 1'b1, 1'b1, 4'd0, 1'b1, 2);
    txn("illegal_size", 32'h1010, 2'b11, 2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 2);

    // Reset mid-scan at idx 3 with every entry OFF.
    clear_tables();
    @(negedge clk);
    req_valid  = 1'b1;
    req_addr   = 32'h5000;
    req_size   = 2'b00;
    req_type   = 2'b00;
    req_priv_m = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid.scanning", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid.resp_valid", 32'(resp_valid), 32'd0);
    check("mid.req_ready",  32'(req_ready),  32'd1);
    check("mid.fault",      32'(resp_fault), 32'd0);
    check("mid.hit",        32'(resp_hit),   32'd0);
    check("mid.entry",      32'(resp_entry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 4) @(posedge clk);
    #1;
    check("mid.no_resp", 32'(resp_valid), 32'd0);

    // Normal operation resumes.
    cfg[0]  = 8'h19;
    addr[0] = 32'h0000_1003;
    txn("post_rst", 32'h1000, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
